gpr_mp: RTL
===========

# gpr_mp

Parametrised multi-port general-purpose register file, successor to the single-write-port GPR in the CPU datapath. It provides two asynchronous read ports and two synchronous write ports, a hardwired zero register and a per-register busy scoreboard for hazard detection. It sits between the decode stage, which reads operands and marks destinations busy, and write-back, which writes results and clears busy.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- RA  input  ADDR_W  read port A index.
- RB  input  ADDR_W  read port B index.
- BusA  output  DATA_W  read data for port A.
- BusB  output  DATA_W  read data for port B.
- BusyA  output  1  busy bit of register RA.
- BusyB  output  1  busy bit of register RB.
- WE0  input  1  write enable, port 0.
- RW0  input  ADDR_W  write index, port 0.
- WD0  input  DATA_W  write data, port 0.
- WE1  input  1  write enable, port 1.
- RW1  input  ADDR_W  write index, port 1.
- WD1  input  DATA_W  write data, port 1.
- SET  input  1  mark register RS busy.
- RS  input  ADDR_W  register index for SET.

## Operation
- Storage is 2**ADDR_W × DATA_W registers plus 2**ADDR_W busy bits.
- Reset (reset = 0): all registers and all busy bits clear to 0 immediately, without waiting for clk. With no writes pending, BusA = BusB = 0 and BusyA = BusyB = 0.
- Write: on a rising edge with WEn = 1, register RWn takes WDn.
- Write conflict: if WE0 = WE1 = 1 and RW0 = RW1, port 1 wins.
- Zero register (ZERO_REG = 1): writes to index 0 are dropped; reads of index 0 return 0; busy bit 0 never sets and always reads 0.
- Scoreboard: on an edge, SET = 1 sets busy[RS]. Any accepted write (WEn = 1) clears busy[RWn].
- Simultaneous set and clear on the same index: set wins, so a new producer overrides a retiring one.
- Reads are combinational from array state. Bypass behaviour is defined under Configuration.
- Busy outputs are combinational from busy state and are never bypassed.

## Timing
- Write latency: data is visible on BusA/BusB in the cycle after the edge. The exception is bypass, which makes it visible in the same cycle.
- Busy latency: a set or clear is visible on BusyA/BusyB in the cycle after the edge.
- Reset asserted mid-operation: state clears asynchronously. Any write or SET on an edge coinciding with reset = 0 is discarded.
- After reset deasserts, the first rising edge performs normal operation.
- Out-of-range inputs do not exist: every ADDR_W index is valid.

## Configuration
- GPR_MP_BYPASS_EN defined:
  - If a read index equals an active same-cycle write index (WEn = 1), the corresponding Bus output shows that write data combinationally.
  - Port 1 takes priority over port 0.
  - The zero register is still forced to 0.
- GPR_MP_BYPASS_EN undefined: reads return stored array contents only, and new data appears the cycle after the write edge.

## Test plan
- Reset state: hold reset = 0 with RA = 3, RB = 31 -> BusA = 0, BusB = 0, BusyA = 0, BusyB = 0. Assert reset mid-cycle after writing 0xAAAA to r5 -> r5 reads 0 immediately.
- Basic write/read: WE0 = 1, RW0 = 10, WD0 = 100; next cycle RB = 10 -> BusB = 100. WE1 = 1, RW1 = 20, WD1 = 200; next cycle RA = 20 -> BusA = 200.
- Zero register: WE0 = 1, RW0 = 0, WD0 = 100; then RA = 0 -> BusA = 0. With ZERO_REG = 0, same stimulus -> BusA = 100.
- Write conflict: WE0 = WE1 = 1, RW0 = RW1 = 7, WD0 = 0x11, WD1 = 0x22 -> r7 reads 0x22.
- Scoreboard:
  - SET = 1, RS = 9 -> BusyA = 1 for RA = 9 next cycle.
  - WE0 = 1, RW0 = 9 -> busy clears next cycle.
  - SET = 1, RS = 9 in the same cycle as WE1 = 1, RW1 = 9 -> busy stays 1 and the data is written.
- Bypass: RA = 12, WE0 = 1, RW0 = 12, WD0 = 0x55 before the edge.
  - With GPR_MP_BYPASS_EN: BusA = 0x55 in the same cycle.
  - Without it: BusA shows the old value until after the edge.

Source files
------------

// File: rtl/gpr_mp.sv
// Multi-port register file: two async read ports, two sync write ports, hardwired
// zero register and per-register busy scoreboard. Optional write->read bypass: GPR_MP_BYPASS_EN.
module gpr_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              BusyA,
    output logic              BusyB,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [DATA_W-1:0] WD0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              SET,
    input  logic [ADDR_W-1:0] RS
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;

    // Port 1 is applied last so it wins a same-index write conflict.
    always_comb begin
        regs_d = regs_q;
        if (WE0) regs_d[RW0] = WD0;
        if (WE1) regs_d[RW1] = WD1;
        if (ZERO_REG != 0) regs_d[0] = '0;
    end

    // Clears first, set last: a new producer overrides a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (WE0) busy_d[RW0] = 1'b0;
        if (WE1) busy_d[RW1] = 1'b0;
        if (SET) busy_d[RS]  = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] d;
        d = regs_q[ra];
`ifdef GPR_MP_BYPASS_EN
        if (WE1 && (RW1 == ra))      d = WD1;
        else if (WE0 && (RW0 == ra)) d = WD0;
`endif
        if ((ZERO_REG != 0) && (ra == '0)) d = '0;
        return d;
    endfunction

    always_comb begin
        BusA  = read_port(RA);
        BusB  = read_port(RB);
        BusyA = busy_q[RA];
        BusyB = busy_q[RB];
    end

endmodule
